// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with one-hot and binary grant outputs.
// Owners hold while requesting, up to a burst limit when others wait.
module onehot_rr_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = $clog2(N),
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             switch_pulse
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [IDX_W-1:0] ptr, ptr_d;
    logic [CNT_W-1:0] hold_cnt, cnt_d;
    logic [N-1:0]     grant_d;
    logic [IDX_W-1:0] idx_d;
    logic             valid_d;
    logic             pulse_d;

    logic [N-1:0]     owner_mask;
    logic             others;
    logic             owner_req;
    logic             at_limit;
    logic [IDX_W-1:0] next_start;
    logic [IDX_W-1:0] w;

    // First requester at or after start, wrapping, optionally skipping excl.
    function automatic logic [IDX_W-1:0] pick(
        input logic [N-1:0]     r,
        input logic [IDX_W-1:0] start,
        input logic             use_excl,
        input logic [IDX_W-1:0] excl
    );
        logic [IDX_W-1:0] idx;
        logic             found;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = start + IDX_W'(k);
            if (!found && r[idx] && !(use_excl && idx == excl)) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    assign owner_mask = N'(1) << grant_idx;
    assign others     = |(req & ~owner_mask);
    assign owner_req  = req[grant_idx];
    assign at_limit   = (hold_cnt == CNT_W'(MAX_HOLD));
    assign next_start = grant_idx + IDX_W'(1);

    // Next-state and next-output decision for the arbitration FSM.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = hold_cnt;
        grant_d = grant;
        idx_d   = grant_idx;
        valid_d = grant_valid;
        pulse_d = 1'b0;
        w       = '0;
        unique case (state)
            IDLE: begin
                grant_d = '0;
                valid_d = 1'b0;
                if (|req) begin
                    w       = pick(req, ptr, 1'b0, '0);
                    grant_d = N'(1) << w;
                    idx_d   = w;
                    valid_d = 1'b1;
                    pulse_d = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                unique case (1'b1)
                    (!owner_req || (at_limit && others)): begin
                        ptr_d = next_start;
                        if (others) begin
                            w       = pick(req, next_start, 1'b1, grant_idx);
                            grant_d = N'(1) << w;
                            idx_d   = w;
                            pulse_d = 1'b1;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            grant_d = '0;
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        if (!at_limit) begin
                            cnt_d = hold_cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous reset drops any grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            hold_cnt     <= '0;
            grant        <= '0;
            grant_idx    <= '0;
            grant_valid  <= 1'b0;
            switch_pulse <= 1'b0;
        end else begin
            state        <= state_d;
            ptr          <= ptr_d;
            hold_cnt     <= cnt_d;
            grant        <= grant_d;
            grant_idx    <= idx_d;
            grant_valid  <= valid_d;
            switch_pulse <= pulse_d;
        end
    end

endmodule

// File: doc/onehot_rr_arbiter.md
Name: onehot_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among N requesters.
- Each grant is issued in two forms: one-hot (`grant`) and binary (`grant_idx`), so downstream one-hot decoder/encoder paths can be driven and cross-checked directly.
- A grant is held while its requester keeps `req` high, up to a MAX_HOLD-cycle burst limit.
- Sits in front of the shared datapath and sequences access to it.

Parameters:
- N, 8, number of requesters (power of 2, 2..16).
- IDX_W, $clog2(N), width of binary grant index.
- MAX_HOLD, 16, cycles an owner may hold the grant before forced rotation when others are waiting (>=1).
- CNT_W, $clog2(MAX_HOLD+1), hold counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- req  input  N  request vector; req[i] high = requester i wants or holds the resource.
- grant  output  N  one-hot grant; all-zero when no grant.
- grant_idx  output  IDX_W  binary index of the current owner.
- grant_valid  output  1  high while any grant is active.
- switch_pulse  output  1  one-cycle pulse in the cycle a new owner's grant first appears.

Behaviour:
- All outputs registered. Internal state: `state` (IDLE/GRANT), `ptr` (IDX_W), `hold_cnt` (CNT_W).
- Reset (rst_n==0 at posedge): grant=0, grant_idx=0, grant_valid=0, switch_pulse=0, ptr=0, hold_cnt=0, state=IDLE.
  - Reset takes priority over everything, including mid-grant; a grant in progress is dropped with no completion cycle.
- Search function pick(start, excl):
  - Returns the first index i with req[i]==1, scanning start, start+1, ..., N-1, 0, ..., start-1 (modulo-N wrap).
  - Skips index excl when an exclusion is requested.
- IDLE state:
  - If |req==0: stay IDLE; outputs keep grant=0, grant_valid=0; grant_idx retains its last value.
  - Else: w=pick(ptr). Next edge: grant=1<<w, grant_idx=w, grant_valid=1, switch_pulse=1, hold_cnt=1, state=GRANT.
  - Latency from req assertion to grant is 1 cycle.
- GRANT state, with owner o = grant_idx and others = |(req & ~(1<<o)):
  - Release (req[o]==0):
    - ptr <= o+1 (mod N).
    - If others: w=pick(o+1, excl o); grant moves to w next edge with no idle bubble; switch_pulse=1; hold_cnt=1.
    - Else: grant=0, grant_valid=0, state=IDLE.
  - Preempt (req[o]==1, hold_cnt==MAX_HOLD, others): same as release-with-others. Grant moves to pick(o+1, excl o), ptr <= o+1, switch_pulse=1, hold_cnt=1.
  - Hold (req[o]==1, otherwise): grant unchanged; switch_pulse=0; hold_cnt <= min(hold_cnt+1, MAX_HOLD).
    - The counter saturates at MAX_HOLD, so a lone owner keeps the grant indefinitely.
- switch_pulse is 0 in every cycle not listed above.
  - Re-granting the same index after an IDLE gap still pulses.
- Invariants, checked every cycle:
  - grant is one-hot-or-zero.
  - grant_valid == |grant.
  - grant_valid implies grant == 1<<grant_idx.
  - A granted index always had req high in the preceding cycle.
- Fairness: with all N requesting continuously, each requester is granted exactly once per N grants, in ascending wrap-around order.
- Simultaneous requests in IDLE: the lowest index at or after ptr wins.
- req changes on non-owner bits during a hold have no effect until release or preempt.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> grant=0, grant_valid=0, grant_idx=0, switch_pulse=0 throughout.
- From reset, req=8'b0010_0100 held; owner drops req after 3 granted cycles -> grant=8'h04, grant_idx=2 one cycle after req. After release, grant=8'h20, grant_idx=5 with switch_pulse=1 and no gap. ptr=3.
- req=8'hFF continuous with MAX_HOLD=16 -> grant_idx sequence 0,1,2,...,7,0 with each owner holding exactly 16 cycles; switch_pulse every 16th cycle.
- Lone requester req=8'h80 held 40 cycles -> grant=8'h80 for all 40 cycles, hold_cnt saturates at 16, no preemption, single switch_pulse.
- Wrap-around: owner idx 6 releases while req=8'b0000_0011 -> next grant idx 0, then ptr=7 and a later IDLE request pattern 8'b1000_0001 is granted to idx 7.
- rst_n=0 for one cycle mid-grant (owner idx 4, hold_cnt=5) -> next edge all outputs 0, ptr=0. With req=8'h18 after reset, grant goes to idx 3.
